// File: rtl/burst_crop_serializer.sv
// Crops an OUT_ROWS x OUT_COLS window from a burst-packed pixel stream and
// serialises the in-window lanes one pixel per beat with SOF/EOL/EOF markers.
module burst_crop_serializer #(
    parameter int unsigned PIXEL_BIT_WIDTH  = 16,
    parameter int unsigned PIXELS_PER_BURST = 16,
    parameter int unsigned USER_WIDTH       = 4,
    parameter int unsigned IN_ROWS          = 100,
    parameter int unsigned IN_COLS          = 160,
    parameter int unsigned OUT_ROWS         = 48,
    parameter int unsigned OUT_COLS         = 48,
    parameter int unsigned IMG_ROW_BITWIDTH = 10,
    parameter int unsigned IMG_COL_BITWIDTH = 10
) (
    input  logic                                         clk,
    input  logic                                         srst,
    input  logic                                         s_axis_resetn,
    input  logic                                         s_axis_tvalid,
    output logic                                         s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0]  s_axis_tdata,
    input  logic [USER_WIDTH-1:0]                        s_axis_tuser,
    input  logic [IMG_COL_BITWIDTH-1:0]                  crop_x0,
    input  logic [IMG_ROW_BITWIDTH-1:0]                  crop_y0,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]                   m_axis_tdata,
    output logic [USER_WIDTH-1:0]                        m_axis_tuser,
    output logic                                         m_axis_tlast
);

    localparam int unsigned BEATS = IN_COLS / PIXELS_PER_BURST;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LW    = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
    localparam int unsigned CW    = IMG_COL_BITWIDTH + 1;
    localparam int unsigned RW    = IMG_ROW_BITWIDTH + 1;
    localparam int unsigned DW    = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
    localparam logic [IMG_COL_BITWIDTH-1:0] X0_MAX = IMG_COL_BITWIDTH'(IN_COLS - OUT_COLS);
    localparam logic [IMG_ROW_BITWIDTH-1:0] Y0_MAX = IMG_ROW_BITWIDTH'(IN_ROWS - OUT_ROWS);

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t                        state_q, state_d;
    logic [IMG_ROW_BITWIDTH-1:0]   row_q, row_d;
    logic [BW-1:0]                 beat_q, beat_d;
    logic [CW-1:0]                 x0_q, x0_d, base_q, base_d;
    logic [RW-1:0]                 y0_q, y0_d;
    logic [DW-1:0]                 data_q, data_d;
    logic [LW-1:0]                 lane_q, lane_d, hi_q, hi_d;
    logic                          frow_q, frow_d, lrow_q, lrow_d;
    logic                          m_valid_q, m_valid_d;
    logic [PIXEL_BIT_WIDTH-1:0]    m_data_q, m_data_d;
    logic [USER_WIDTH-1:0]         m_user_q, m_user_d;

    logic                          rst, sof, accept, load, in_win, row_in;
    logic                          first_row, last_row;
    logic [CW-1:0]                 live_x0, x0_sel, base, win_last, burst_last, lo_abs, hi_abs;
    logic [RW-1:0]                 live_y0, y0_sel, row_ext;
    logic [BW-1:0]                 pos_beat;
    logic [IMG_ROW_BITWIDTH-1:0]   pos_row;
    logic [LW-1:0]                 lo_lane, hi_lane, lane_inc;
    logic                          tuser_unused;

    // Marker bits for one output pixel at absolute column col.
    function automatic logic [USER_WIDTH-1:0] markers(input logic [CW-1:0] col,
                                                      input logic [CW-1:0] x0,
                                                      input logic frow, input logic lrow);
        logic [USER_WIDTH-1:0] u;
        logic                  row_end;
        u       = '0;
        row_end = (col == x0 + CW'(OUT_COLS - 1));
        u[0]    = frow && (col == x0);
        u[1]    = row_end;
        u[2]    = row_end && lrow;
        return u;
    endfunction

    assign rst          = srst || !s_axis_resetn;
    assign sof          = s_axis_tuser[0];
    assign tuser_unused = ^s_axis_tuser[USER_WIDTH-1:1];

    assign s_axis_tready = !rst && ((state_q == IDLE) ||
                           (lane_q == hi_q && m_valid_q && m_axis_tready));
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_user_q[2];

    // Window geometry of the beat on the input; an SOF beat uses the live crop.
    always_comb begin
        live_x0    = CW'((crop_x0 > X0_MAX) ? X0_MAX : crop_x0);
        live_y0    = RW'((crop_y0 > Y0_MAX) ? Y0_MAX : crop_y0);
        x0_sel     = sof ? live_x0 : x0_q;
        y0_sel     = sof ? live_y0 : y0_q;
        pos_beat   = sof ? '0 : beat_q;
        pos_row    = sof ? '0 : row_q;
        base       = CW'(pos_beat) * CW'(PIXELS_PER_BURST);
        win_last   = x0_sel + CW'(OUT_COLS - 1);
        burst_last = base + CW'(PIXELS_PER_BURST - 1);
        lo_abs     = (x0_sel > base) ? x0_sel : base;
        hi_abs     = (win_last < burst_last) ? win_last : burst_last;
        row_ext    = RW'(pos_row);
        row_in     = (row_ext >= y0_sel) && (row_ext < y0_sel + RW'(OUT_ROWS));
        in_win     = row_in && (lo_abs <= hi_abs);
        lo_lane    = LW'(lo_abs - base);
        hi_lane    = LW'(hi_abs - base);
        first_row  = (row_ext == y0_sel);
        last_row   = (row_ext == y0_sel + RW'(OUT_ROWS - 1));
        lane_inc   = lane_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        beat_d    = beat_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        data_d    = data_q;
        lane_d    = lane_q;
        hi_d      = hi_q;
        base_d    = base_q;
        frow_d    = frow_q;
        lrow_d    = lrow_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        load      = 1'b0;

        if (accept) begin
            if (pos_beat == BW'(BEATS - 1)) begin
                beat_d = '0;
                row_d  = (pos_row == IMG_ROW_BITWIDTH'(IN_ROWS - 1)) ? '0 : pos_row + 1'b1;
            end else begin
                beat_d = pos_beat + 1'b1;
                row_d  = pos_row;
            end
            if (sof) begin
                x0_d = live_x0;
                y0_d = live_y0;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept && in_win) load = 1'b1;
            end
            SERIAL: begin
                if (m_valid_q && m_axis_tready) begin
                    if (lane_q != hi_q) begin
                        lane_d   = lane_inc;
                        m_data_d = data_q[lane_inc*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
                        m_user_d = markers(base_q + CW'(lane_inc), x0_q, frow_q, lrow_q);
                    end else if (accept && in_win) begin
                        load = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        m_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Store a new in-window beat and present its first lane immediately.
        if (load) begin
            state_d   = SERIAL;
            data_d    = s_axis_tdata;
            lane_d    = lo_lane;
            hi_d      = hi_lane;
            base_d    = base;
            frow_d    = first_row;
            lrow_d    = last_row;
            m_valid_d = 1'b1;
            m_data_d  = s_axis_tdata[lo_lane*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
            m_user_d  = markers(lo_abs, x0_sel, first_row, last_row);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            beat_q    <= '0;
            x0_q      <= live_x0;
            y0_q      <= live_y0;
            data_q    <= '0;
            lane_q    <= '0;
            hi_q      <= '0;
            base_q    <= '0;
            frow_q    <= 1'b0;
            lrow_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            beat_q    <= beat_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            data_q    <= data_d;
            lane_q    <= lane_d;
            hi_q      <= hi_d;
            base_q    <= base_d;
            frow_q    <= frow_d;
            lrow_q    <= lrow_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
        end
    end

endmodule

// File: tb/tb_burst_crop_serializer.sv
// Directed bench for burst_crop_serializer: table of frame scenarios plus
// hand-written reset sequences. Pixel payload encodes {row, column}.
module tb_burst_crop_serializer;

    localparam int unsigned W   = 16;
    localparam int unsigned PPB = 16;
    localparam int unsigned UW  = 4;
    localparam int unsigned DW  = W * PPB;

    logic          clk = 1'b0;
    logic          srst, s_axis_resetn;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [UW-1:0] s_axis_tuser;
    logic [9:0]    crop_x0, crop_y0;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [W-1:0]  m_axis_tdata;
    logic [UW-1:0] m_axis_tuser;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    burst_crop_serializer dut (
        .clk           (clk),
        .srst          (srst),
        .s_axis_resetn (s_axis_resetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .crop_x0       (crop_x0),
        .crop_y0       (crop_y0),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast)
    );

    // One scenario: live crop A, switched to B at beat chg_at; optional second SOF at
    // beat sof2; expected output = na pixels of window A then nb pixels of window B.
    typedef struct {
        int    x0a, y0a, x0b, y0b, chg_at, n_beats, sof2;
        bit    sof0;
        int    pct;
        int    ex0a, ey0a, na, ex0b, ey0b, nb;
        string name;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_beat(input int row, input int bcol);
        for (int l = 0; l < PPB; l++)
            s_axis_tdata[l*W +: W] = {8'(row), 8'(bcol * PPB + l)};
    endtask

    task automatic run_case(input vec_t v);
        int sent = 0, got = 0, cyc = 0, extra = 0, last_cyc = 0;
        int bad_data = 0, bad_user = 0, bad_gap = 0, bad_stab = 0;
        int nexp, budget, p, k, ex, ey, er, ec;
        bit held = 1'b0, allow_last, sof_bit;
        logic [W-1:0]  hd, exp_d;
        logic [UW-1:0] hu, exp_u;
        logic          hl;
        nexp   = v.na + v.nb;
        budget = 3 * v.n_beats + 3 * nexp + 2000;
        crop_x0 = 10'(v.x0a);
        crop_y0 = 10'(v.y0a);
        while ((sent < v.n_beats || got < nexp) && cyc < budget) begin
            @(negedge clk);
            if (v.chg_at >= 0 && sent >= v.chg_at) begin
                crop_x0 = 10'(v.x0b);
                crop_y0 = 10'(v.y0b);
            end
            m_axis_tready = ($urandom_range(99) < v.pct);
            if (sent < v.n_beats) begin
                p       = (v.sof2 >= 0 && sent >= v.sof2) ? sent - v.sof2 : sent;
                sof_bit = (p == 0) && (v.sof0 || sent > 0);
                s_axis_tvalid = 1'b1;
                s_axis_tuser  = {1'($urandom_range(1)), 2'b00, sof_bit};
                fill_beat((p / 10) % 100, p % 10);
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tuser  = '0;
            end
            #1;
            if (held && (!m_axis_tvalid || m_axis_tdata != hd || m_axis_tuser != hu ||
                         m_axis_tlast != hl))
                bad_stab++;
            held = m_axis_tvalid && !m_axis_tready;
            hd = m_axis_tdata;
            hu = m_axis_tuser;
            hl = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                if (got < v.na) begin
                    k = got; ex = v.ex0a; ey = v.ey0a; allow_last = (v.na == 2304);
                end else begin
                    k = got - v.na; ex = v.ex0b; ey = v.ey0b; allow_last = 1'b1;
                end
                er    = ey + k / 48;
                ec    = ex + k % 48;
                exp_d = {8'(er), 8'(ec)};
                exp_u = {1'b0, (allow_last && k == 2303), (k % 48 == 47), (k == 0)};
                if (got >= nexp) begin
                    extra++;
                end else begin
                    if (m_axis_tdata != exp_d) bad_data++;
                    if (m_axis_tuser != exp_u || m_axis_tlast != exp_u[2]) bad_user++;
                    if (v.pct == 100 && k % 48 != 0 && cyc - last_cyc != 1) bad_gap++;
                end
                last_cyc = cyc;
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            cyc++;
        end
        repeat (40) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            s_axis_tuser  = '0;
            m_axis_tready = 1'b1;
            #1;
            if (m_axis_tvalid) extra++;
        end
        check({v.name, " beats_accepted"}, sent, v.n_beats);
        check({v.name, " pixel_count"}, got + extra, nexp);
        check({v.name, " pixel_data_errors"}, bad_data, 0);
        check({v.name, " marker_errors"}, bad_user, 0);
        check({v.name, " unstable_while_stalled"}, bad_stab, 0);
        check({v.name, " bubbles_inside_row"}, bad_gap, 0);
    endtask

    initial begin
        srst          = 1'b1;
        s_axis_resetn = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        crop_x0       = 10'd8;
        crop_y0       = 10'd2;

        tbl[0] = '{8, 2, 8, 2, -1, 1000, -1, 1'b1, 100, 8, 2, 2304, 0, 0, 0, "default"};
        tbl[1] = '{150, 90, 150, 90, -1, 1000, -1, 1'b1, 100, 112, 52, 2304, 0, 0, 0, "clamp"};
        tbl[2] = '{8, 2, 8, 2, -1, 1000, -1, 1'b1, 50, 8, 2, 2304, 0, 0, 0, "rand_ready"};
        tbl[3] = '{8, 2, 0, 0, 500, 2000, 1000, 1'b1, 100, 8, 2, 2304, 0, 0, 2304, "two_frames"};
        tbl[4] = '{8, 2, 8, 2, -1, 1214, 214, 1'b1, 100, 8, 2, 960, 8, 2, 2304, "mid_window_sof"};
        tbl[5] = '{200, 200, 200, 200, -1, 1000, -1, 1'b1, 70, 112, 52, 2304, 0, 0, 0, "clamp_rand"};
        tbl[6] = '{8, 2, 8, 2, -1, 1000, -1, 1'b1, 80, 8, 2, 2304, 0, 0, 0, "after_srst"};
        tbl[7] = '{16, 4, 0, 0, 0, 1000, -1, 1'b0, 100, 16, 4, 2304, 0, 0, 0, "reset_latched_crop"};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset tvalid", m_axis_tvalid, 0);
        check("reset tdata", m_axis_tdata, 0);
        check("reset tuser", m_axis_tuser, 0);
        check("reset tlast", m_axis_tlast, 0);
        check("reset s_tready", s_axis_tready, 0);
        srst = 1'b0;
        #1;
        check("post_reset s_tready", s_axis_tready, 1);

        for (int i = 0; i < 6; i++) run_case(tbl[i]);

        // srst while a full 16-lane beat is being serialised
        @(negedge clk);
        crop_x0 = 10'd0;
        crop_y0 = 10'd0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 4'b0001;
        fill_beat(0, 0);
        #1;
        check("srst_seq idle ready", s_axis_tready, 1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = '0;
        #1;
        check("srst_seq first pixel", m_axis_tdata, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("srst_seq serial valid", m_axis_tvalid, 1);
        srst = 1'b1;
        @(negedge clk);
        #1;
        check("srst_seq tvalid cleared", m_axis_tvalid, 0);
        check("srst_seq ready in reset", s_axis_tready, 0);
        srst = 1'b0;
        #1;
        check("srst_seq ready after", s_axis_tready, 1);
        run_case(tbl[6]);

        // Stream clear latches the live crop; the following frame has no SOF
        @(negedge clk);
        crop_x0 = 10'd16;
        crop_y0 = 10'd4;
        s_axis_resetn = 1'b0;
        @(negedge clk);
        #1;
        check("resetn tvalid", m_axis_tvalid, 0);
        check("resetn ready in reset", s_axis_tready, 0);
        s_axis_resetn = 1'b1;
        #1;
        check("resetn ready after", s_axis_tready, 1);
        run_case(tbl[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
